// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one fully pipelined cordic between several requesters.
// Optional statistics counters are compiled in with `define CORDIC_SCHED_STATS_EN.
module cordic_scheduler #(
  parameter int width           = 16,
  parameter int iterations      = width + 2,
  parameter int latency         = iterations,
  parameter int ports           = 2,
  parameter int max_outstanding = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ports-1:0]         req_valid,
  output logic [ports-1:0]         req_ready,
  input  logic [ports*width-1:0]   req_x,
  input  logic [ports*width-1:0]   req_y,
  input  logic [ports*width-1:0]   req_z,
  output logic [width-1:0]         c_x0,
  output logic [width-1:0]         c_y0,
  output logic [width-1:0]         c_z0,
  input  logic [width:0]           c_x,
  input  logic [width:0]           c_y,
  input  logic [width-1:0]         c_z,
  output logic [ports-1:0]         res_valid,
  output logic [width:0]           res_x,
  output logic [width:0]           res_y,
  output logic [width-1:0]         res_z,
  output logic                     busy
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_blocked
`endif
);

  localparam int PW = (ports > 1) ? $clog2(ports) : 1;
  localparam int CW = $clog2(max_outstanding + 1);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    outst_q [ports];
  logic [CW-1:0]    outst_d [ports];
  logic [latency-1:0] tag_vld_q;
  logic [PW-1:0]    tag_port_q [latency];
  logic [ports-1:0] eligible, grant;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;
  logic             ret_vld;
  logic [PW-1:0]    ret_port;
  logic [width-1:0] c_x0_q, c_y0_q, c_z0_q;
  logic [width:0]   res_x_q, res_y_q;
  logic [width-1:0] res_z_q;
  logic [ports-1:0] res_valid_q;
  int               sel_base;

  // Handshake: a request transfers in any cycle where req_valid[p] and req_ready[p]
  // are both high; req_ready is a combinational one-hot grant and never waits on ready.
  always_comb begin
    for (int p = 0; p < ports; p++) begin
      eligible[p] = req_valid[p] && (outst_q[p] < CW'(max_outstanding));
    end
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= ports; i++) begin
      int cand;
      cand = int'(ptr_q) + i;
      if (cand >= ports) cand = cand - ports;
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = PW'(cand);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    ptr_d    = grant_any ? grant_idx : ptr_q;
    sel_base = int'(grant_idx) * width;
  end

  assign req_ready = grant & {ports{reset_n}};

  // The tag at the last stage lines up with the cordic result on c_x/c_y/c_z.
  assign ret_vld  = tag_vld_q[latency-1];
  assign ret_port = tag_port_q[latency-1];

  always_comb begin
    for (int p = 0; p < ports; p++) begin
      outst_d[p] = outst_q[p];
      if (grant_any && grant_idx == PW'(p) && !(ret_vld && ret_port == PW'(p)))
        outst_d[p] = outst_q[p] + CW'(1);
      else if (ret_vld && ret_port == PW'(p) && !(grant_any && grant_idx == PW'(p)))
        outst_d[p] = outst_q[p] - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= PW'(ports - 1);
      tag_vld_q   <= '0;
      c_x0_q      <= '0;
      c_y0_q      <= '0;
      c_z0_q      <= '0;
      res_valid_q <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_z_q     <= '0;
      for (int p = 0; p < ports; p++) outst_q[p] <= '0;
      for (int i = 0; i < latency; i++) tag_port_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int p = 0; p < ports; p++) outst_q[p] <= outst_d[p];
      tag_vld_q[0]  <= grant_any;
      tag_port_q[0] <= grant_idx;
      for (int i = 1; i < latency; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_port_q[i] <= tag_port_q[i-1];
      end
      c_x0_q <= grant_any ? req_x[sel_base +: width] : '0;
      c_y0_q <= grant_any ? req_y[sel_base +: width] : '0;
      c_z0_q <= grant_any ? req_z[sel_base +: width] : '0;
      res_valid_q <= '0;
      if (ret_vld) begin
        res_valid_q[ret_port] <= 1'b1;
        res_x_q <= c_x;
        res_y_q <= c_y;
        res_z_q <= c_z;
      end
    end
  end

`ifdef CORDIC_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_blocked_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued_q  <= '0;
      stat_blocked_q <= '0;
    end else begin
      if (grant_any) stat_issued_q <= stat_issued_q + 32'd1;
      if ((|req_valid) && !(|eligible)) stat_blocked_q <= stat_blocked_q + 32'd1;
    end
  end
  assign stat_issued  = stat_issued_q;
  assign stat_blocked = stat_blocked_q;
`endif

  assign c_x0      = c_x0_q;
  assign c_y0      = c_y0_q;
  assign c_z0      = c_z0_q;
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_z     = res_z_q;
  assign busy      = (|tag_vld_q) | (|res_valid_q);

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: stand-in cordic pipeline, arbitration/outstanding reference
// model and a result scoreboard driven by randomized request traffic.
module tb_cordic_scheduler;
  localparam int W     = 16;
  localparam int LAT   = W + 2;
  localparam int PORTS = 2;
  localparam int MAXO  = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [PORTS-1:0]     req_valid = '0;
  logic [PORTS-1:0]     req_ready;
  logic [PORTS*W-1:0]   req_x = '0, req_y = '0, req_z = '0;
  logic [W-1:0]         c_x0, c_y0, c_z0;
  logic [W:0]           c_x, c_y;
  logic [W-1:0]         c_z;
  logic [PORTS-1:0]     res_valid;
  logic [W:0]           res_x, res_y;
  logic [W-1:0]         res_z;
  logic                 busy;

  always #5 clk = ~clk;

  cordic_scheduler #(.width(W), .iterations(LAT), .latency(LAT), .ports(PORTS),
                     .max_outstanding(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .c_x0(c_x0), .c_y0(c_y0), .c_z0(c_z0), .c_x(c_x), .c_y(c_y), .c_z(c_z),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z), .busy(busy)
  );

  // Stand-in cordic: fixed function of the operands, result LAT cycles after the grant cycle.
  function automatic logic [3*W+1:0] cordic_fn(input logic [W-1:0] x, y, z);
    logic signed [W:0] rx, ry;
    rx = $signed({x[W-1], x}) + $signed({{2{y[W-1]}}, y[W-1:1]});
    ry = $signed({y[W-1], y}) - $signed({x[W-1], x});
    return {rx, ry, z ^ 16'h5A5A};
  endfunction

  logic [W-1:0] px [1:LAT-1];
  logic [W-1:0] py [1:LAT-1];
  logic [W-1:0] pz [1:LAT-1];
  always_ff @(posedge clk) begin
    px[1] <= c_x0;
    py[1] <= c_y0;
    pz[1] <= c_z0;
    for (int i = 2; i < LAT; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
      pz[i] <= pz[i-1];
    end
  end
  assign {c_x, c_y, c_z} = cordic_fn(px[LAT-1], py[LAT-1], pz[LAT-1]);

  // Reference model state
  typedef struct packed {
    logic [7:0]  port;
    logic [31:0] done;
    logic [W:0]  x;
    logic [W:0]  y;
    logic [W-1:0] z;
  } exp_t;
  exp_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  int          cnt_m [PORTS];
  int          ptr_m = PORTS - 1;
  logic [W:0]  last_rx = '0, last_ry = '0;
  logic [W-1:0] last_rz = '0;
  logic [W-1:0] last_cx = '0, last_cy = '0, last_cz = '0;
  logic [W-1:0] zsweep = 16'h8000;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic drive(input int mode);
    for (int p = 0; p < PORTS; p++) begin
      req_x[p*W +: W] = W'($urandom);
      req_y[p*W +: W] = W'($urandom);
      req_z[p*W +: W] = W'($urandom);
    end
    case (mode)
      1: begin
        req_valid = 2'b01;
        req_x[0 +: W] = 16'h7FFF;
        req_y[0 +: W] = '0;
        req_z[0 +: W] = '0;
      end
      2: req_valid = PORTS'($urandom_range(0, 3));
      3: req_valid = 2'b10;
      4: req_valid = 2'b11;
      5: begin
        req_valid = 2'b11;
        for (int p = 0; p < PORTS; p++) req_z[p*W +: W] = zsweep + W'(p);
        zsweep = zsweep + W'(PORTS);
      end
      default: req_valid = '0;
    endcase
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int p = 0; p < PORTS; p++) cnt_m[p] = 0;
    ptr_m = PORTS - 1;
    last_rx = '0; last_ry = '0; last_rz = '0;
    last_cx = '0; last_cy = '0; last_cz = '0;
  endtask

  task automatic cycle_step(input int mode);
    logic [PORTS-1:0] exp_rv, exp_gnt;
    logic             exp_busy;
    int               g;
    exp_t             e;
    @(posedge clk);
    #1;
    t++;
    drive(mode);
    @(negedge clk);
    exp_busy = (exp_q.size() != 0);
    exp_rv   = '0;
    if (exp_q.size() != 0 && exp_q[0].done == 32'(t)) begin
      e = exp_q.pop_front();
      exp_rv[e.port] = 1'b1;
      cnt_m[e.port]--;
      last_rx = e.x; last_ry = e.y; last_rz = e.z;
    end
    g = -1;
    for (int i = 1; i <= PORTS; i++) begin
      int c;
      c = (ptr_m + i) % PORTS;
      if (g < 0 && req_valid[c] && cnt_m[c] < MAXO) g = c;
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check_eq("req_ready", req_ready, exp_gnt);
    check_eq("res_valid", res_valid, exp_rv);
    check_eq("res_x", res_x, last_rx);
    check_eq("res_y", res_y, last_ry);
    check_eq("res_z", res_z, last_rz);
    check_eq("busy", busy, exp_busy);
    check_eq("c_op", {c_x0, c_y0, c_z0}, {last_cx, last_cy, last_cz});
    if (g >= 0) begin
      last_cx = req_x[g*W +: W];
      last_cy = req_y[g*W +: W];
      last_cz = req_z[g*W +: W];
      e.port = 8'(g);
      e.done = 32'(t + LAT + 1);
      {e.x, e.y, e.z} = cordic_fn(last_cx, last_cy, last_cz);
      exp_q.push_back(e);
      cnt_m[g]++;
      ptr_m = g;
    end else begin
      last_cx = '0; last_cy = '0; last_cz = '0;
    end
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) cycle_step(mode);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    req_valid = '0;
    #1;
    check_eq("rst_ready", req_ready, '0);
    check_eq("rst_res_valid", res_valid, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_res", {res_x, res_y, res_z}, '0);
    check_eq("rst_c_op", {c_x0, c_y0, c_z0}, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int grants;
    model_reset();
    #3;
    check_eq("init_ready", req_ready, '0);
    check_eq("init_res_valid", res_valid, '0);
    check_eq("init_busy", busy, 1'b0);
    check_eq("init_c_op", {c_x0, c_y0, c_z0}, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run(0, 3);
    run(1, 1);
    run(0, LAT + 4);

    grants = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      cycle_step(3);
      if (req_ready[1]) grants++;
    end
    check_eq("throttle_grants", 64'(grants), 64'(MAXO));
    run(3, 30);
    run(0, LAT + 3);

    run(4, 60);
    run(2, 300);
    run(5, 200);
    run(0, LAT + 3);

    run(4, 3);
    async_reset();
    run(0, LAT + 3);
    run(4, 40);
    run(2, 200);
    run(0, LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
